pe_operand_collector: RTL and testbench
=======================================

Name: pe_operand_collector

Overview:
- Operand-collection stage directly upstream of the PE ALU.
- Accepts one instruction context: opcode, two source selects and a constant.
- Captures the selected operands from the four mesh inputs, the constant, or the ALU loop-back register, waiting for each 33-bit value's valid bit (bit 32).
- Once the instruction's firing rule is met, issues registered op_LHS/op_RHS/op_SHIFT/op_predicate/operation to the ALU for exactly one cycle, and latches the ALU result back as the next op_SHIFT.

Parameters:
- WIDTH, 32: data width; bit WIDTH is the valid bit on 33-bit buses.
- TIMEOUT, 255: maximum COLLECT cycles before abandoning an instruction.
- TO_W, 8: width of the collect timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cfg_valid  in  1  instruction context offered.
- cfg_ready  out  1  collector can accept a context.
- cfg_op  in  6  ALU operation code; bit 5 selects the shift operand.
- cfg_lhs_sel  in  3  0=N, 1=E, 2=S, 3=W, 4=const, 5=loop-back, 6/7=unused.
- cfg_rhs_sel  in  3  same encoding as cfg_lhs_sel.
- cfg_const  in  32  immediate value.
- in_north, in_east, in_south, in_west  in  33 each  mesh inputs; bit 32 = valid.
- alu_result  in  32  combinational result from the ALU.
- op_LHS  out  33  to ALU.
- op_RHS  out  33  to ALU.
- op_SHIFT  out  33  loop-back register, to ALU.
- op_predicate  out  32  to ALU.
- operation  out  6  to ALU.
- alu_fire  out  1  ALU issue strobe.
- collect_timeout  out  1  one-cycle pulse when an instruction is abandoned.

Behaviour:
- Reset:
  - state=IDLE.
  - All outputs, operand registers, captured flags, timeout counter and op_SHIFT = 0.
  - cfg_ready=1 on the first cycle after reset.
  - Reset in any state aborts the instruction; no alu_fire and no loop-back update.
- State IDLE:
  - cfg_ready=1.
  - On cfg_valid: latch op, both selects and const; clear lhs_got/rhs_got and the counter; go to COLLECT.
- State COLLECT:
  - cfg_ready=0; cfg_valid is ignored.
  - Each edge, per side with got=0:
    - sel 0-3: capture the input if its bit 32 is 1.
    - sel 4: capture {1, cfg_const}.
    - sel 5: capture op_SHIFT if op_SHIFT[32]=1.
    - sel 6/7: got=1 immediately with value 0 (bit 32=0).
  - A captured value is held; later input changes are ignored.
  - Firing rule:
    - Opcode 5'b10000 (select): fire when either side is captured with bit 32=1, or both sides are done.
    - All other opcodes: both sides captured.
  - Captures made on the same edge count towards the rule; the state becomes ISSUE on that edge.
  - The counter increments each COLLECT cycle. Reaching TIMEOUT without firing: pulse collect_timeout for 1 cycle, go to IDLE, no fire.
- State ISSUE (exactly 1 cycle):
  - alu_fire=1, operation=latched op.
  - op_LHS/op_RHS = captured values.
  - op_predicate = {31'b0, lhs[32] & rhs[32]}.
  - On the closing edge: op_SHIFT <= {1, alu_result}; go to IDLE.
- Outside ISSUE:
  - operation=0 (ALU nop), op_LHS=op_RHS=0, op_predicate=0, alu_fire=0.
  - op_SHIFT holds its value.
- Latency:
  - cfg_valid accepted at edge T.
  - Operands already valid during cycle T+1 are captured at edge T+1.
  - alu_fire is high in cycle T+2 (minimum 2 cycles from acceptance).
- Back-to-back: a new context can be accepted in the cycle after ISSUE. Throughput is at most 1 instruction per 3 cycles.
- op_SHIFT mode: with cfg_op[5]=1 the ALU reads op_SHIFT. Its valid bit is 0 until the first issue after reset.

Test Plan:
- Add: reset; cfg op=000001, lhs=N, rhs=E; in_north={1,5} and in_east={1,7} in the cycle after accept -> alu_fire 2 cycles after accept, op_LHS=0x1_00000005, op_RHS=0x1_00000007, op_predicate=1; next cycle op_SHIFT=0x1_0000000C.
- Staggered arrival: N valid at cycle 1, E valid at cycle 4 -> fire in cycle 5. The N value captured at cycle 1 is kept even though in_north changes to {1,99} at cycle 3.
- Select: op=010000, lhs=S, rhs=W; only W={1,0x33} arrives -> fire with op_RHS=0x1_00000033 and op_LHS=0.
- Loop-back: after the first test, op=100001, rhs=const 3, lhs=5 -> fires 2 cycles after accept; operation=100001, op_SHIFT=0x1_0000000C.
- Timeout: lhs=N, no valid input ever arrives -> collect_timeout pulses after 255 COLLECT cycles, alu_fire is never raised, cfg_ready=1 on the next cycle.
- Reset mid-COLLECT (one operand captured) -> next cycle state=IDLE, op_SHIFT=0, no fire; a fresh context then completes normally.

Source files
------------

// File: rtl/pe_operand_collector.sv
// Operand collector ahead of the PE ALU: alu_fire is high for one cycle, at least 2 cycles after a context is accepted.
// cfg_ready is low from acceptance until the cycle after issue or timeout; throughput is at most 1 instruction per 3 cycles.
module pe_operand_collector #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [5:0]       cfg_op,
  input  logic [2:0]       cfg_lhs_sel,
  input  logic [2:0]       cfg_rhs_sel,
  input  logic [WIDTH-1:0] cfg_const,
  input  logic [WIDTH:0]   in_north,
  input  logic [WIDTH:0]   in_east,
  input  logic [WIDTH:0]   in_south,
  input  logic [WIDTH:0]   in_west,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH:0]   op_LHS,
  output logic [WIDTH:0]   op_RHS,
  output logic [WIDTH:0]   op_SHIFT,
  output logic [WIDTH-1:0] op_predicate,
  output logic [5:0]       operation,
  output logic             alu_fire,
  output logic             collect_timeout
);

  typedef enum logic [1:0] {IDLE, COLLECT, ISSUE} state_t;

  state_t           state;
  logic [5:0]       lat_op;
  logic [2:0]       lat_lhs_sel;
  logic [2:0]       lat_rhs_sel;
  logic [WIDTH-1:0] lat_const;
  logic             lhs_got;
  logic             rhs_got;
  logic [WIDTH:0]   lhs_val;
  logic [WIDTH:0]   rhs_val;
  logic [TO_W-1:0]  to_cnt;

  logic [WIDTH+1:0] lhs_pick;
  logic [WIDTH+1:0] rhs_pick;
  logic             lhs_got_n;
  logic             rhs_got_n;
  logic [WIDTH:0]   lhs_val_n;
  logic [WIDTH:0]   rhs_val_n;
  logic             is_select;
  logic             fire;
  logic             timeout_hit;

  // Returns {captured, value}; unused selects count as captured with an invalid zero.
  function automatic logic [WIDTH+1:0] pick(
    input logic [2:0]       sel,
    input logic [WIDTH:0]   n,
    input logic [WIDTH:0]   e,
    input logic [WIDTH:0]   s,
    input logic [WIDTH:0]   w,
    input logic [WIDTH-1:0] cst,
    input logic [WIDTH:0]   shf
  );
    logic [WIDTH+1:0] r;
    r = '0;
    case (sel)
      3'd0:    r = {n[WIDTH], n};
      3'd1:    r = {e[WIDTH], e};
      3'd2:    r = {s[WIDTH], s};
      3'd3:    r = {w[WIDTH], w};
      3'd4:    r = {1'b1, 1'b1, cst};
      3'd5:    r = {shf[WIDTH], shf};
      default: r = {1'b1, {(WIDTH+1){1'b0}}};
    endcase
    return r;
  endfunction

  assign lhs_pick = pick(lat_lhs_sel, in_north, in_east, in_south, in_west, lat_const, op_SHIFT);
  assign rhs_pick = pick(lat_rhs_sel, in_north, in_east, in_south, in_west, lat_const, op_SHIFT);

  always_comb begin
    lhs_got_n = lhs_got;
    lhs_val_n = lhs_val;
    rhs_got_n = rhs_got;
    rhs_val_n = rhs_val;
    if (!lhs_got && lhs_pick[WIDTH+1]) begin
      lhs_got_n = 1'b1;
      lhs_val_n = lhs_pick[WIDTH:0];
    end
    if (!rhs_got && rhs_pick[WIDTH+1]) begin
      rhs_got_n = 1'b1;
      rhs_val_n = rhs_pick[WIDTH:0];
    end
  end

  // Select fires on the first valid operand, or once both sides have resolved.
  assign is_select   = (lat_op[4:0] == 5'b10000);
  assign fire        = is_select ? ((lhs_got_n && lhs_val_n[WIDTH]) ||
                                    (rhs_got_n && rhs_val_n[WIDTH]) ||
                                    (lhs_got_n && rhs_got_n))
                                 : (lhs_got_n && rhs_got_n);
  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT - 1));
  assign cfg_ready   = (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      lat_op          <= '0;
      lat_lhs_sel     <= '0;
      lat_rhs_sel     <= '0;
      lat_const       <= '0;
      lhs_got         <= 1'b0;
      rhs_got         <= 1'b0;
      lhs_val         <= '0;
      rhs_val         <= '0;
      to_cnt          <= '0;
      op_LHS          <= '0;
      op_RHS          <= '0;
      op_SHIFT        <= '0;
      op_predicate    <= '0;
      operation       <= '0;
      alu_fire        <= 1'b0;
      collect_timeout <= 1'b0;
    end else begin
      op_LHS          <= '0;
      op_RHS          <= '0;
      op_predicate    <= '0;
      operation       <= '0;
      alu_fire        <= 1'b0;
      collect_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            lat_op      <= cfg_op;
            lat_lhs_sel <= cfg_lhs_sel;
            lat_rhs_sel <= cfg_rhs_sel;
            lat_const   <= cfg_const;
            lhs_got     <= 1'b0;
            rhs_got     <= 1'b0;
            lhs_val     <= '0;
            rhs_val     <= '0;
            to_cnt      <= '0;
            state       <= COLLECT;
          end
        end
        COLLECT: begin
          lhs_got <= lhs_got_n;
          rhs_got <= rhs_got_n;
          lhs_val <= lhs_val_n;
          rhs_val <= rhs_val_n;
          if (fire) begin
            alu_fire     <= 1'b1;
            operation    <= lat_op;
            op_LHS       <= lhs_val_n;
            op_RHS       <= rhs_val_n;
            op_predicate <= {{(WIDTH-1){1'b0}}, lhs_val_n[WIDTH] & rhs_val_n[WIDTH]};
            state        <= ISSUE;
          end else if (timeout_hit) begin
            collect_timeout <= 1'b1;
            state           <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ISSUE: begin
          op_SHIFT <= {1'b1, alu_result};
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_operand_collector.sv
// Bench for pe_operand_collector: directed vector table, multi-cycle corner sequences and a randomized arrival-schedule model.
module tb_pe_operand_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [5:0]  cfg_op;
  logic [2:0]  cfg_lhs_sel;
  logic [2:0]  cfg_rhs_sel;
  logic [31:0] cfg_const;
  logic [32:0] mesh [4];
  logic [31:0] alu_result;
  logic [32:0] op_LHS;
  logic [32:0] op_RHS;
  logic [32:0] op_SHIFT;
  logic [31:0] op_predicate;
  logic [5:0]  operation;
  logic        alu_fire;
  logic        collect_timeout;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [32:0] model_shift;

  always #5 clk = ~clk;

  // Stand-in ALU: adds the two operand payloads.
  assign alu_result = op_LHS[31:0] + op_RHS[31:0];

  pe_operand_collector dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_op(cfg_op),
    .cfg_lhs_sel(cfg_lhs_sel), .cfg_rhs_sel(cfg_rhs_sel), .cfg_const(cfg_const),
    .in_north(mesh[0]), .in_east(mesh[1]), .in_south(mesh[2]), .in_west(mesh[3]),
    .alu_result(alu_result),
    .op_LHS(op_LHS), .op_RHS(op_RHS), .op_SHIFT(op_SHIFT),
    .op_predicate(op_predicate), .operation(operation),
    .alu_fire(alu_fire), .collect_timeout(collect_timeout)
  );

  typedef struct {
    logic [5:0]  op;
    logic [2:0]  ls;
    logic [2:0]  rs;
    logic [31:0] cst;
    logic [32:0] n, e, s, w;
    logic [32:0] xl, xr;
    logic        xp;
    logic [32:0] xs;
  } vec_t;

  vec_t vt [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mesh();
    for (int d = 0; d < 4; d++) mesh[d] = '0;
  endtask

  task automatic accept(input logic [5:0] op, input logic [2:0] ls, input logic [2:0] rs,
                        input logic [31:0] cst);
    cfg_op = op; cfg_lhs_sel = ls; cfg_rhs_sel = rs; cfg_const = cst;
    cfg_valid = 1'b1;
    check("cfg_ready_at_accept", 64'(cfg_ready), 64'd1);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic check_issue(input string tag, input logic [32:0] xl, input logic [32:0] xr,
                             input logic [5:0] xop);
    check({tag, "_fire"}, 64'(alu_fire), 64'd1);
    check({tag, "_lhs"}, 64'(op_LHS), 64'(xl));
    check({tag, "_rhs"}, 64'(op_RHS), 64'(xr));
    check({tag, "_pred"}, 64'(op_predicate), 64'(xl[32] & xr[32]));
    check({tag, "_operation"}, 64'(operation), 64'(xop));
  endtask

  initial begin
    logic [5:0]  op;
    logic [2:0]  ls, rs;
    logic [31:0] cst;
    int          arr [4];
    logic [31:0] base [4];
    int          cl, cr, fe, k;
    logic [32:0] vl, vr, xl, xr;
    logic        early, seen;

    vt[0] = '{6'b000001, 3'd0, 3'd1, 32'h0, 33'h1_0000_0005, 33'h1_0000_0007, 33'h0, 33'h0,
              33'h1_0000_0005, 33'h1_0000_0007, 1'b1, 33'h1_0000_000C};
    vt[1] = '{6'b000010, 3'd2, 3'd3, 32'h0, 33'h0, 33'h0, 33'h1_0000_0010, 33'h1_0000_0020,
              33'h1_0000_0010, 33'h1_0000_0020, 1'b1, 33'h1_0000_0030};
    vt[2] = '{6'b000011, 3'd4, 3'd0, 32'h100, 33'h1_0000_0001, 33'h0, 33'h0, 33'h0,
              33'h1_0000_0100, 33'h1_0000_0001, 1'b1, 33'h1_0000_0101};
    vt[3] = '{6'b000011, 3'd6, 3'd7, 32'h0, 33'h1_0000_0009, 33'h1_0000_0009, 33'h0, 33'h0,
              33'h0, 33'h0, 1'b0, 33'h1_0000_0000};
    vt[4] = '{6'b010000, 3'd2, 3'd3, 32'h0, 33'h0, 33'h0, 33'h0_0000_0044, 33'h1_0000_0033,
              33'h0, 33'h1_0000_0033, 1'b0, 33'h1_0000_0033};
    vt[5] = '{6'b100001, 3'd5, 3'd4, 32'h3, 33'h0, 33'h0, 33'h0, 33'h0,
              33'h1_0000_0033, 33'h1_0000_0003, 1'b1, 33'h1_0000_0036};

    reset = 1'b1; cfg_valid = 1'b0; cfg_op = '0; cfg_lhs_sel = '0; cfg_rhs_sel = '0; cfg_const = '0;
    clear_mesh();
    step(); step();
    reset = 1'b0;
    check("rst_ready", 64'(cfg_ready), 64'd1);
    check("rst_fire", 64'(alu_fire), 64'd0);
    check("rst_shift", 64'(op_SHIFT), 64'd0);
    check("rst_timeout", 64'(collect_timeout), 64'd0);
    check("rst_operation", 64'(operation), 64'd0);
    check("rst_lhs", 64'(op_LHS), 64'd0);

    // Directed table: operands present from acceptance, so issue lands 2 cycles later.
    for (int i = 0; i < 6; i++) begin
      mesh[0] = vt[i].n; mesh[1] = vt[i].e; mesh[2] = vt[i].s; mesh[3] = vt[i].w;
      accept(vt[i].op, vt[i].ls, vt[i].rs, vt[i].cst);
      check("tbl_no_early_fire", 64'(alu_fire), 64'd0);
      check("tbl_busy", 64'(cfg_ready), 64'd0);
      step();
      check_issue("tbl", vt[i].xl, vt[i].xr, vt[i].op);
      check("tbl_pred_exp", 64'(op_predicate), 64'(vt[i].xp));
      step();
      clear_mesh();
      check("tbl_shift", 64'(op_SHIFT), 64'(vt[i].xs));
      check("tbl_fire_drop", 64'(alu_fire), 64'd0);
      check("tbl_ready_after", 64'(cfg_ready), 64'd1);
    end
    model_shift = 33'h1_0000_0036;

    // Staggered arrival; north changes after capture and must be ignored.
    accept(6'b000001, 3'd0, 3'd1, 32'h0);
    mesh[0] = 33'h1_0000_0011;
    step();
    check("stag_c2_nofire", 64'(alu_fire), 64'd0);
    step();
    mesh[0] = 33'h1_0000_0063;
    step();
    mesh[1] = 33'h1_0000_0004;
    check("stag_c4_nofire", 64'(alu_fire), 64'd0);
    step();
    check_issue("stag", 33'h1_0000_0011, 33'h1_0000_0004, 6'b000001);
    step();
    clear_mesh();
    check("stag_shift", 64'(op_SHIFT), 64'h1_0000_0015);

    // Timeout: nothing ever arrives.
    accept(6'b000001, 3'd0, 3'd1, 32'h0);
    k = 1; seen = 1'b0;
    while (k < 400 && !collect_timeout) begin
      if (alu_fire) seen = 1'b1;
      step();
      k++;
    end
    check("to_pulse_cycle", 64'(k), 64'd256);
    check("to_no_fire", 64'(seen), 64'd0);
    step();
    check("to_pulse_len", 64'(collect_timeout), 64'd0);
    check("to_ready", 64'(cfg_ready), 64'd1);
    check("to_shift_kept", 64'(op_SHIFT), 64'h1_0000_0015);

    // Reset mid-collect with one operand already captured.
    accept(6'b000001, 3'd0, 3'd1, 32'h0);
    mesh[0] = 33'h1_0000_0021;
    step();
    reset = 1'b1;
    mesh[1] = 33'h1_0000_0022;
    step();
    reset = 1'b0;
    clear_mesh();
    check("rstm_ready", 64'(cfg_ready), 64'd1);
    check("rstm_shift", 64'(op_SHIFT), 64'd0);
    check("rstm_fire", 64'(alu_fire), 64'd0);
    step();
    check("rstm_fire2", 64'(alu_fire), 64'd0);
    mesh[0] = 33'h1_0000_0002; mesh[1] = 33'h1_0000_0003;
    accept(6'b000001, 3'd0, 3'd1, 32'h0);
    step();
    check_issue("rstm_fresh", 33'h1_0000_0002, 33'h1_0000_0003, 6'b000001);
    step();
    clear_mesh();
    check("rstm_fresh_shift", 64'(op_SHIFT), 64'h1_0000_0005);
    model_shift = 33'h1_0000_0005;

    // Randomized: each mesh side turns valid at a random cycle, payload changes every cycle.
    for (int it = 0; it < 40; it++) begin
      op = 6'($urandom);
      if ($urandom_range(0, 2) == 0) op[4:0] = 5'b10000;
      ls = 3'($urandom_range(0, 7));
      rs = 3'($urandom_range(0, 7));
      if (ls == 3'd5 && !model_shift[32]) ls = 3'd4;
      if (rs == 3'd5 && !model_shift[32]) rs = 3'd4;
      cst = $urandom;
      for (int d = 0; d < 4; d++) begin
        arr[d] = $urandom_range(1, 6);
        base[d] = $urandom;
      end
      cl = 1; cr = 1;
      case (ls)
        3'd0, 3'd1, 3'd2, 3'd3: begin cl = arr[ls]; vl = {1'b1, base[ls] + 32'(arr[ls])}; end
        3'd4: vl = {1'b1, cst};
        3'd5: vl = model_shift;
        default: vl = '0;
      endcase
      case (rs)
        3'd0, 3'd1, 3'd2, 3'd3: begin cr = arr[rs]; vr = {1'b1, base[rs] + 32'(arr[rs])}; end
        3'd4: vr = {1'b1, cst};
        3'd5: vr = model_shift;
        default: vr = '0;
      endcase
      fe = (cl > cr) ? cl : cr;
      if (op[4:0] == 5'b10000) begin
        if (vl[32] && cl < fe) fe = cl;
        if (vr[32] && cr < fe) fe = cr;
      end
      xl = (cl <= fe) ? vl : 33'h0;
      xr = (cr <= fe) ? vr : 33'h0;

      accept(op, ls, rs, cst);
      early = 1'b0;
      for (int c = 1; c <= fe; c++) begin
        for (int d = 0; d < 4; d++)
          mesh[d] = (c >= arr[d]) ? {1'b1, base[d] + 32'(c)} : {1'b0, 32'($urandom)};
        if (alu_fire) early = 1'b1;
        step();
      end
      check("rnd_early_fire", 64'(early), 64'd0);
      check_issue("rnd", xl, xr, op);
      step();
      clear_mesh();
      model_shift = {1'b1, xl[31:0] + xr[31:0]};
      check("rnd_shift", 64'(op_SHIFT), 64'(model_shift));
      check("rnd_ready", 64'(cfg_ready), 64'd1);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
